// File: rtl/riscv_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : riscv_dmem_arbiter
// Purpose  : Shares the single data-cache port between the CPU load/store
//            path and an external requester (UART loader / debug port).
//            Each access is sequenced IDLE -> ISSUE -> WAIT -> DONE with a
//            fixed memory read latency. The CPU has priority, and a
//            starvation counter guarantees that the external side progresses.
// Ports    : clk, rst (async, active-low)
//            cpu_req/we/addr/wdata -> cpu_rdata, cpu_ack
//            ext_req/we/addr/wdata -> ext_rdata, ext_ack
//            mem_en/we/addr/wdata  -> data cache, mem_rdata <- data cache
//            owner : 00 none, 01 CPU, 10 external
// Revision : 1.0 - initial release
// ============================================================================
module riscv_dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // CPU side
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    // External side
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,
    // Data cache side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // Status
    output logic [1:0]        owner
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // WAIT counter runs MEM_LAT-1 down to 0
    localparam int c_lat_w = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_lat_w-1:0] c_lat_init = c_lat_w'(MEM_LAT - 1);
    localparam logic [c_lat_w-1:0] c_lat_one  = c_lat_w'(1);

    localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);
    localparam logic [c_starve_w-1:0] c_starve_one = c_starve_w'(1);

    localparam logic [1:0] c_own_none = 2'b00;
    localparam logic [1:0] c_own_cpu  = 2'b01;
    localparam logic [1:0] c_own_ext  = 2'b10;

    // ------------------------------------------------------------------
    // State and latched request fields
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_lat_w-1:0]    r_lat_cnt;
    logic [c_starve_w-1:0] r_starve_cnt;

    logic                  r_own_ext;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;

    // Registered outputs
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [1:0]            r_owner;
    logic                  r_cpu_ack;
    logic                  r_ext_ack;
    logic [DATA_W-1:0]     r_cpu_rdata;
    logic [DATA_W-1:0]     r_ext_rdata;

    // Arbitration and next-output values
    logic                  w_any_req;
    logic                  w_grant_ext;
    logic                  w_fld_ext;
    logic                  w_fld_we;
    logic [ADDR_W-1:0]     w_fld_addr;
    logic [DATA_W-1:0]     w_fld_wdata;
    logic                  w_mem_active_nxt;
    logic                  w_mem_en_nxt;
    logic                  w_mem_we_nxt;
    logic [ADDR_W-1:0]     w_mem_addr_nxt;
    logic [DATA_W-1:0]     w_mem_wdata_nxt;
    logic [1:0]            w_owner_nxt;
    logic                  w_cpu_ack_nxt;
    logic                  w_ext_ack_nxt;
    logic                  w_capture;

    // External wins a contested slot only once the CPU has used up its
    // allowance of consecutive grants.
    assign w_any_req   = cpu_req | ext_req;
    assign w_grant_ext = ext_req & (~cpu_req | (r_starve_cnt == c_starve_max));

    // Last WAIT cycle: read data from the cache is valid now
    assign w_capture   = (r_state == c_st_wait) && (r_lat_cnt == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_any_req)         w_state_nxt = c_st_issue;
            c_st_issue:                        w_state_nxt = c_st_wait;
            c_st_wait:  if (r_lat_cnt == '0)   w_state_nxt = c_st_done;
            c_st_done:                         w_state_nxt = c_st_idle;
            default:                           w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Outputs are registered, so this computes what
    // they must show in the state being entered. While leaving IDLE the
    // latched fields are not loaded yet, so the winner's inputs are used.
    // ------------------------------------------------------------------
    always_comb begin
        w_fld_ext   = r_own_ext;
        w_fld_we    = r_we;
        w_fld_addr  = r_addr;
        w_fld_wdata = r_wdata;
        if (r_state == c_st_idle) begin
            w_fld_ext   = w_grant_ext;
            w_fld_we    = w_grant_ext ? ext_we    : cpu_we;
            w_fld_addr  = w_grant_ext ? ext_addr  : cpu_addr;
            w_fld_wdata = w_grant_ext ? ext_wdata : cpu_wdata;
        end

        // Address/data/we stay on the bus through ISSUE and WAIT
        w_mem_active_nxt = (w_state_nxt == c_st_issue) || (w_state_nxt == c_st_wait);
        w_mem_en_nxt     = (w_state_nxt == c_st_issue);
        w_mem_we_nxt     = w_mem_active_nxt & w_fld_we;
        w_mem_addr_nxt   = w_mem_active_nxt ? w_fld_addr  : '0;
        w_mem_wdata_nxt  = w_mem_active_nxt ? w_fld_wdata : '0;

        w_owner_nxt      = c_own_none;
        if (w_state_nxt != c_st_idle) begin
            w_owner_nxt  = w_fld_ext ? c_own_ext : c_own_cpu;
        end

        w_cpu_ack_nxt    = (w_state_nxt == c_st_done) & ~w_fld_ext;
        w_ext_ack_nxt    = (w_state_nxt == c_st_done) &  w_fld_ext;
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_owner     <= c_own_none;
            r_cpu_ack   <= 1'b0;
            r_ext_ack   <= 1'b0;
        end else begin
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_owner     <= w_owner_nxt;
            r_cpu_ack   <= w_cpu_ack_nxt;
            r_ext_ack   <= w_ext_ack_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Grant latch and starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_own_ext    <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_starve_cnt <= '0;
        end else if ((r_state == c_st_idle) && w_any_req) begin
            r_own_ext <= w_grant_ext;
            r_we      <= w_grant_ext ? ext_we    : cpu_we;
            r_addr    <= w_grant_ext ? ext_addr  : cpu_addr;
            r_wdata   <= w_grant_ext ? ext_wdata : cpu_wdata;
            // Only CPU grants that overtake a waiting external request count
            if (w_grant_ext || !ext_req) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != c_starve_max) begin
                r_starve_cnt <= r_starve_cnt + c_starve_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lat_cnt <= '0;
        end else if (r_state == c_st_issue) begin
            r_lat_cnt <= c_lat_init;
        end else if ((r_state == c_st_wait) && (r_lat_cnt != '0)) begin
            r_lat_cnt <= r_lat_cnt - c_lat_one;
        end
    end

    // ------------------------------------------------------------------
    // Read data capture into the owner's register. Writes capture too;
    // the value is simply not meaningful then.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cpu_rdata <= '0;
            r_ext_rdata <= '0;
        end else if (w_capture) begin
            if (r_own_ext) begin
                r_ext_rdata <= mem_rdata;
            end else begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign owner     = r_owner;
    assign cpu_ack   = r_cpu_ack;
    assign ext_ack   = r_ext_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign ext_rdata = r_ext_rdata;

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_dmem_arbiter
// Purpose  : Self-checking bench for riscv_dmem_arbiter. Two instances are
//            used: index 0 with MEM_LAT=1 and index 1 with MEM_LAT=3. A
//            transaction-level model (time elapsed since grant) predicts the
//            outputs of both every cycle; directed sequences add literal
//            expectations, then a randomized phase runs against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_dmem_arbiter;

    localparam int c_limit = 4;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic [31:0] cpu_rdata [2];
    logic        cpu_ack   [2];
    logic        ext_req   [2];
    logic        ext_we    [2];
    logic [31:0] ext_addr  [2];
    logic [31:0] ext_wdata [2];
    logic [31:0] ext_rdata [2];
    logic        ext_ack   [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [1:0]  owner     [2];

    riscv_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(c_limit)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]),
        .ext_req(ext_req[0]), .ext_we(ext_we[0]), .ext_addr(ext_addr[0]), .ext_wdata(ext_wdata[0]),
        .ext_rdata(ext_rdata[0]), .ext_ack(ext_ack[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .owner(owner[0])
    );

    riscv_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_LIMIT(c_limit)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]),
        .ext_req(ext_req[1]), .ext_we(ext_we[1]), .ext_addr(ext_addr[1]), .ext_wdata(ext_wdata[1]),
        .ext_rdata(ext_rdata[1]), .ext_ack(ext_ack[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .owner(owner[1])
    );

    // ------------------------------------------------------------------
    // Reference model state: one access in flight, timed by cycles since
    // the grant edge (t=1 strobe, t=LAT+2 acknowledge, t=LAT+3 idle again).
    // ------------------------------------------------------------------
    bit          m_busy  [2];
    int          m_t     [2];
    bit          m_ext   [2];
    bit          m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    int          m_starve[2];

    // Memory model: read data valid exactly LAT cycles after the strobe
    int          rd_cd   [2];
    logic [31:0] rd_addr [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] memf(logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, d, cyc, act, exp);
        end
    endtask

    task automatic model_edge(int d);
        if (!rst) begin
            m_busy[d]   = 1'b0;
            m_starve[d] = 0;
            return;
        end
        if (m_busy[d]) begin
            m_t[d]++;
            if (m_t[d] == lat_of(d) + 3) m_busy[d] = 1'b0;
        end else if (cpu_req[d] || ext_req[d]) begin
            m_ext[d] = ext_req[d] && (!cpu_req[d] || m_starve[d] == c_limit);
            if (m_ext[d] || !ext_req[d]) m_starve[d] = 0;
            else if (m_starve[d] < c_limit) m_starve[d]++;
            m_we[d]    = m_ext[d] ? ext_we[d]    : cpu_we[d];
            m_addr[d]  = m_ext[d] ? ext_addr[d]  : cpu_addr[d];
            m_wdata[d] = m_ext[d] ? ext_wdata[d] : cpu_wdata[d];
            m_busy[d]  = 1'b1;
            m_t[d]     = 1;
        end
    endtask

    task automatic compare(int d);
        bit         en_e  = m_busy[d] && (m_t[d] == 1);
        bit         ack_e = m_busy[d] && (m_t[d] == lat_of(d) + 2);
        logic [1:0] own_e = !m_busy[d] ? 2'b00 : (m_ext[d] ? 2'b10 : 2'b01);
        chk("mem_en",  d, 32'(mem_en[d]),  32'(en_e));
        chk("owner",   d, 32'(owner[d]),   32'(own_e));
        chk("cpu_ack", d, 32'(cpu_ack[d]), 32'(ack_e && !m_ext[d]));
        chk("ext_ack", d, 32'(ext_ack[d]), 32'(ack_e && m_ext[d]));
        if (en_e) begin
            chk("mem_we",   d, 32'(mem_we[d]), 32'(m_we[d]));
            chk("mem_addr", d, mem_addr[d], m_addr[d]);
            if (m_we[d]) chk("mem_wdata", d, mem_wdata[d], m_wdata[d]);
        end
        if (ack_e && !m_we[d]) begin
            if (m_ext[d]) chk("ext_rdata", d, ext_rdata[d], memf(m_addr[d]));
            else          chk("cpu_rdata", d, cpu_rdata[d], memf(m_addr[d]));
        end
    endtask

    task automatic mem_drive(int d);
        logic [31:0] v;
        v = $urandom;
        if (rd_cd[d] > 0) begin
            rd_cd[d]--;
            if (rd_cd[d] == 0) v = memf(rd_addr[d]);
        end
        mem_rdata[d] = v;
        if (mem_en[d] === 1'b1 && mem_we[d] === 1'b0) begin
            rd_cd[d]   = lat_of(d);
            rd_addr[d] = mem_addr[d];
        end
    endtask

    // One clock: model steps on the edge, DUT sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            compare(d);
            mem_drive(d);
        end
    endtask

    task automatic set_cpu(int d, bit req, bit we, logic [31:0] a, logic [31:0] wd);
        cpu_req[d] = req; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = wd;
    endtask

    task automatic set_ext(int d, bit req, bit we, logic [31:0] a, logic [31:0] wd);
        ext_req[d] = req; ext_we[d] = we; ext_addr[d] = a; ext_wdata[d] = wd;
    endtask

    // Requester behaviour: hold until ack, occasionally abandon, and
    // scramble fields once granted (the arbiter must have latched them).
    task automatic rand_drive(int d);
        if (cpu_req[d]) begin
            if (cpu_ack[d] === 1'b1)
                set_cpu(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            else if ($urandom_range(0, 15) == 0)
                cpu_req[d] = 1'b0;
            else if (m_busy[d] && !m_ext[d])
                set_cpu(d, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end else if ($urandom_range(0, 1) == 1) begin
            set_cpu(d, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        if (ext_req[d]) begin
            if (ext_ack[d] === 1'b1)
                set_ext(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            else if ($urandom_range(0, 15) == 0)
                ext_req[d] = 1'b0;
            else if (m_busy[d] && m_ext[d])
                set_ext(d, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end else if ($urandom_range(0, 1) == 1) begin
            set_ext(d, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
    endtask

    initial begin
        int exp_own [6];
        int prev;
        int waited;
        int n_en;

        exp_own = '{1, 1, 1, 1, 2, 1};
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            set_cpu(d, 1'b0, 1'b0, 32'h0, 32'h0);
            set_ext(d, 1'b0, 1'b0, 32'h0, 32'h0);
            mem_rdata[d] = 32'h0;
            m_busy[d] = 1'b0; m_t[d] = 0; m_ext[d] = 1'b0; m_we[d] = 1'b0;
            m_addr[d] = 32'h0; m_wdata[d] = 32'h0; m_starve[d] = 0;
            rd_cd[d] = 0; rd_addr[d] = 32'h0;
        end

        // Reset state
        tick(); tick();
        chk("rst_mem_en",  0, 32'(mem_en[0]),  32'h0);
        chk("rst_owner",   0, 32'(owner[0]),   32'h0);
        chk("rst_cpu_ack", 0, 32'(cpu_ack[0]), 32'h0);
        chk("rst_rdata",   1, cpu_rdata[1],    32'h0);
        rst = 1'b1;
        tick();

        // 1: CPU load 0x10 returning DEADBEEF
        set_cpu(0, 1'b1, 1'b0, 32'h10, 32'h0);
        tick();
        chk("t1_mem_en",   0, 32'(mem_en[0]), 32'h1);
        chk("t1_mem_addr", 0, mem_addr[0],    32'h10);
        tick(); tick();
        chk("t1_cpu_ack",   0, 32'(cpu_ack[0]), 32'h1);
        chk("t1_cpu_rdata", 0, cpu_rdata[0],    32'hDEAD_BEEF);
        cpu_req[0] = 1'b0;
        tick();
        chk("t1_ack_once", 0, 32'(cpu_ack[0]), 32'h0);

        // 2: external write 0x40 <= 0x12345678
        set_ext(0, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
        tick();
        chk("t2_mem_en",    0, 32'(mem_en[0] & mem_we[0]), 32'h1);
        chk("t2_mem_wdata", 0, mem_wdata[0], 32'h1234_5678);
        chk("t2_owner1",    0, 32'(owner[0]), 32'h2);
        tick();
        chk("t2_owner2",    0, 32'(owner[0]), 32'h2);
        tick();
        chk("t2_ext_ack",   0, 32'(ext_ack[0]), 32'h1);
        chk("t2_cpu_ack",   0, 32'(cpu_ack[0]), 32'h0);
        chk("t2_owner3",    0, 32'(owner[0]), 32'h2);
        ext_req[0] = 1'b0;
        tick();
        chk("t2_owner_idle", 0, 32'(owner[0]), 32'h0);

        // 3: both requesters held -> CPU x4, then external
        set_cpu(0, 1'b1, 1'b0, 32'h100, 32'h0);
        set_ext(0, 1'b1, 1'b0, 32'h200, 32'h0);
        prev = 0;
        for (int g = 0; g < 6; g++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (mem_en[0] !== 1'b1 && waited < 12);
            chk("t3_grant_seen", 0, 32'(mem_en[0]), 32'h1);
            chk("t3_owner",      0, 32'(owner[0]),  32'(exp_own[g]));
            if (g > 0) chk("t3_spacing", 0, 32'(cyc - prev), 32'd4);
            prev = cyc;
        end
        cpu_req[0] = 1'b0;
        ext_req[0] = 1'b0;
        repeat (4) tick();

        // 4: reset asserted during WAIT, then a clean CPU load
        set_cpu(0, 1'b1, 1'b0, 32'h30, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("t4_mem_en",   0, 32'(mem_en[0]),  32'h0);
        chk("t4_owner",    0, 32'(owner[0]),   32'h0);
        chk("t4_mem_addr", 0, mem_addr[0],     32'h0);
        chk("t4_cpu_ack",  0, 32'(cpu_ack[0]), 32'h0);
        cpu_req[0] = 1'b0;
        tick(); tick();
        rst = 1'b1;
        set_cpu(0, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        chk("t4_mem_addr2", 0, mem_addr[0], 32'h20);
        tick(); tick();
        chk("t4_cpu_ack2",  0, 32'(cpu_ack[0]), 32'h1);
        chk("t4_rdata2",    0, cpu_rdata[0],    memf(32'h20));
        cpu_req[0] = 1'b0;
        tick();

        // 5: MEM_LAT=3 instance, CPU load
        set_cpu(1, 1'b1, 1'b0, 32'h44, 32'h0);
        n_en = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_en += int'(mem_en[1]);
            if (k == 1) chk("t5_mem_en", 1, 32'(mem_en[1]), 32'h1);
            if (k == 4) chk("t5_no_ack_yet", 1, 32'(cpu_ack[1]), 32'h0);
        end
        chk("t5_cpu_ack",  1, 32'(cpu_ack[1]), 32'h1);
        chk("t5_rdata",    1, cpu_rdata[1],    memf(32'h44));
        chk("t5_en_count", 1, 32'(n_en),       32'd1);
        cpu_req[1] = 1'b0;
        tick();

        // 6: request dropped right after grant
        set_cpu(0, 1'b1, 1'b0, 32'h50, 32'h0);
        n_en = 0;
        tick();
        n_en += int'(mem_en[0]);
        cpu_req[0] = 1'b0;
        tick();
        n_en += int'(mem_en[0]);
        tick();
        n_en += int'(mem_en[0]);
        chk("t6_cpu_ack", 0, 32'(cpu_ack[0]), 32'h1);
        tick();
        n_en += int'(mem_en[0]);
        tick();
        n_en += int'(mem_en[0]);
        chk("t6_owner_idle", 0, 32'(owner[0]), 32'h0);
        chk("t6_en_count",   0, 32'(n_en),     32'd1);

        // Randomized traffic against the model on both instances
        for (int i = 0; i < 800; i++) begin
            for (int d = 0; d < 2; d++) rand_drive(d);
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            cpu_req[d] = 1'b0;
            ext_req[d] = 1'b0;
        end
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
